step_input_conditioner: RTL and testbench

- Front-end stage that feeds the sequence detector one operator-entered bit per button press.
- Synchronizes and debounces a raw pushbutton (step) and a raw slide switch (data bit).
- On each accepted press, emits the switch value on sig_to_test with a one-cycle step_valid qualifier.
- Keeps a bit-history shift register and a step counter for board LEDs.

---
 rtl/step_input_conditioner.sv | 138 +++++++++++++
 tb/tb_step_input_conditioner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/step_input_conditioner.sv
// Pushbutton/switch front end: 2-flop synchronizers, debounce FSM, and one accepted bit per press.
// Optional AUTO_REPEAT_EN: while the button is held, a further step is accepted every REPEAT_CYCLES.
module step_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HIST_W          = 8,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_raw,
    input  logic              sw_raw,
    output logic              sig_to_test,
    output logic              step_valid,
    output logic [HIST_W-1:0] history,
    output logic [7:0]        step_count
);
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || HIST_W < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
        $error("step_input_conditioner: DEBOUNCE_CYCLES, HIST_W and REPEAT_CYCLES must be >= 2");
    end

    logic             btn_meta, btn_s;
    logic             sw_meta, sw_s;
    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_accept;
    logic             rep_fire;
    logic             accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            sw_meta  <= 1'b0;
            sw_s     <= 1'b0;
        end else begin
            btn_meta <= btn_raw;
            btn_s    <= btn_meta;
            sw_meta  <= sw_raw;
            sw_s     <= sw_meta;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        press_accept = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt    = PRESSED;
                    press_accept = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                // A re-close during release debounce returns to PRESSED without a new step.
                if (btn_s) begin
                    state_nxt = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt;

    assign rep_fire = (state == PRESSED) && btn_s && (rep_cnt == REP_LAST);

    // Any cycle outside a held PRESSED (entry, exit, or after firing) restarts the period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rep_cnt <= '0;
        else if (state == PRESSED && btn_s && !rep_fire)
            rep_cnt <= rep_cnt + 1'b1;
        else
            rep_cnt <= '0;
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign accept = press_accept | rep_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_to_test <= 1'b0;
            step_valid  <= 1'b0;
            history     <= '0;
            step_count  <= '0;
        end else begin
            step_valid <= accept;
            if (accept) begin
                sig_to_test <= sw_s;
                history     <= {history[HIST_W-2:0], sw_s};
                step_count  <= step_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_step_input_conditioner.sv
// Directed bench for step_input_conditioner (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8); build with
// +define+AUTO_REPEAT_EN to exercise the repeat variant.
module tb_step_input_conditioner;
    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic       sw_raw;
    logic       sig_to_test;
    logic       step_valid;
    logic [7:0] history;
    logic [7:0] step_count;

    int checks = 0;
    int passes = 0;
    int back_to_back = 0;
    logic prev_valid = 1'b0;

    step_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HIST_W(8),
        .REPEAT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .sw_raw(sw_raw),
        .sig_to_test(sig_to_test),
        .step_valid(step_valid),
        .history(history),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n edges, counting step_valid pulses and the first edge (1-based) that showed one.
    task automatic observe(input int n, output int pulses, output int first);
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (step_valid) begin
                pulses++;
                if (first == 0) first = i;
                if (prev_valid) back_to_back++;
            end
            prev_valid = step_valid;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prev_valid = 1'b0;
    endtask

    initial begin
        int p, f, total;
        logic [4:0] seq;
        logic [31:0] exp_rep;
        rst = 1'b1;
        btn_raw = 1'b0;
        sw_raw  = 1'b0;
        tick();
        tick();
        check("reset_sig", sig_to_test, 0);
        check("reset_valid", step_valid, 0);
        check("reset_hist", history, 0);
        check("reset_count", step_count, 0);
        rst = 1'b0;
        tick();

        // Clean press with switch high: step on edge 7, nothing on release.
        sw_raw  = 1'b1;
        btn_raw = 1'b1;
        observe(20, p, f);
        check("clean_pulses", p, 1);
        check("clean_latency", f, 7);
        check("clean_sig", sig_to_test, 1);
        check("clean_hist", history, 8'h01);
        check("clean_count", step_count, 1);
        btn_raw = 1'b0;
        observe(12, p, f);
        check("clean_release", p, 0);

        // Bouncy press with switch low.
        sw_raw = 1'b0;
        total  = 0;
        btn_raw = 1'b1; observe(1, p, f); total += p;
        btn_raw = 1'b0; observe(1, p, f); total += p;
        btn_raw = 1'b1; observe(1, p, f); total += p;
        btn_raw = 1'b0; observe(1, p, f); total += p;
        check("bounce_no_step", total, 0);
        btn_raw = 1'b1;
        observe(15, p, f);
        check("bounce_pulses", p, 1);
        check("bounce_latency", f, 7);
        check("bounce_hist", history, 8'h02);
        check("bounce_count", step_count, 2);
        check("bounce_sig", sig_to_test, 0);
        btn_raw = 1'b0;
        observe(12, p, f);
        check("bounce_release", p, 0);

        // Sequence 0,1,0,0,1 from reset.
        do_reset();
        check("rst2_hist", history, 0);
        check("rst2_count", step_count, 0);
        seq = 5'b10010;  // entered LSB first
        total = 0;
        for (int i = 0; i < 5; i++) begin
            sw_raw  = seq[i];
            btn_raw = 1'b1;
            observe(12, p, f);
            total += p;
            btn_raw = 1'b0;
            if (i == 4) sw_raw = 1'b0;  // late switch change must not matter
            observe(12, p, f);
            total += p;
        end
        check("seq_pulses", total, 5);
        check("seq_hist", history, 8'h09);
        check("seq_count", step_count, 5);
        check("seq_sig_held", sig_to_test, 1);

        // Reset while in PRESS_WAIT with cnt=2, button kept held.
        sw_raw  = 1'b1;
        btn_raw = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("midrst_no_step_yet", step_count, 5);
        #2 rst = 1'b1;
        #1;
        check("midrst_hist_async", history, 0);
        check("midrst_count_async", step_count, 0);
        check("midrst_sig_async", sig_to_test, 0);
        tick();
        rst = 1'b0;
        prev_valid = 1'b0;
        observe(12, p, f);
        check("midrst_pulses", p, 1);
        check("midrst_latency", f, 7);
        check("midrst_count", step_count, 1);
        check("midrst_hist", history, 8'h01);
        btn_raw = 1'b0;
        observe(12, p, f);

        // 256 presses wrap the step counter back to 0.
        do_reset();
        total = 0;
        sw_raw = 1'b0;
        for (int i = 0; i < 256; i++) begin
            btn_raw = 1'b1;
            observe(10, p, f);
            total += p;
            btn_raw = 1'b0;
            observe(8, p, f);
            total += p;
            if (i == 254) check("wrap_count_255", step_count, 255);
        end
        check("wrap_pulses", total, 256);
        check("wrap_count", step_count, 0);

        // Hold for 30 cycles: auto-repeat gives steps at edges 7,15,23,31.
`ifdef AUTO_REPEAT_EN
        exp_rep = 4;
`else
        exp_rep = 1;
`endif
        do_reset();
        sw_raw  = 1'b1;
        btn_raw = 1'b1;
        observe(30, p, f);
        total = p;
        check("hold_first_latency", f, 7);
        btn_raw = 1'b0;
        observe(12, p, f);
        total += p;
        check("hold_pulses", total, exp_rep);
        check("hold_count", step_count, exp_rep);

        check("no_back_to_back_valid", back_to_back, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
